// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit bus CPU control path.
//   - opcode constants (IR[7:4])
//   - T-state encoding of the control sequencer (six steps plus HALT)
//   - bit positions of each strobe inside the control word, so a microcode
//     ROM can later be dropped in with the same layout
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-state encoding (binary; code 3'd7 is unused)
  localparam int         STATE_W = 3;
  localparam logic [2:0] ST_T1   = 3'd0;
  localparam logic [2:0] ST_T2   = 3'd1;
  localparam logic [2:0] ST_T3   = 3'd2;
  localparam logic [2:0] ST_T4   = 3'd3;
  localparam logic [2:0] ST_T5   = 3'd4;
  localparam logic [2:0] ST_T6   = 3'd5;
  localparam logic [2:0] ST_HALT = 3'd6;

  // Control word bit positions
  localparam int CW_PC_OUT  = 0;
  localparam int CW_PC_INC  = 1;
  localparam int CW_PC_LOAD = 2;
  localparam int CW_MAR_IN  = 3;
  localparam int CW_RAM_OUT = 4;
  localparam int CW_RAM_IN  = 5;
  localparam int CW_IR_IN   = 6;
  localparam int CW_IR_OUT  = 7;
  localparam int CW_A_IN    = 8;
  localparam int CW_A_OUT   = 9;
  localparam int CW_B_IN    = 10;
  localparam int CW_ALU_OUT = 11;
  localparam int CW_ALU_SUB = 12;
  localparam int CW_OUT_IN  = 13;
  localparam int CW_W       = 14;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Instructions whose T4 step places the operand address into MAR.
  function automatic logic op_loads_mar(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational microcode decode: (T-state, opcode) -> control word.
// Ports:
//   state      in  current T-state code
//   ir_op      in  opcode nibble; only looked at in T4..T6
//   ctrl_word  out one bit per bus strobe (layout from cpu_pkg)
//   last_step  out this step ends the instruction (next edge -> T1)
//   halt_step  out this step is HLT's T4 (next edge -> HALT)
// Parameters:
//   SKIP_NOP   1 = finish on the instruction's last active step,
//              0 = always run through T6
// -----------------------------------------------------------------------------
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter bit SKIP_NOP = 1'b1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [3:0]         ir_op,
  output ctrl_word_t         ctrl_word,
  output logic               last_step,
  output logic               halt_step
);

  // op_last: last active step of the current instruction
  logic op_last;

  always_comb begin
    ctrl_word = '0;
    op_last   = 1'b0;
    halt_step = 1'b0;
    case (state)
      ST_T1: begin
        ctrl_word[CW_PC_OUT] = 1'b1;
        ctrl_word[CW_MAR_IN] = 1'b1;
      end
      ST_T2: begin
        ctrl_word[CW_PC_INC] = 1'b1;
      end
      ST_T3: begin
        ctrl_word[CW_RAM_OUT] = 1'b1;
        ctrl_word[CW_IR_IN]   = 1'b1;
      end
      ST_T4: begin
        if (op_loads_mar(ir_op)) begin
          ctrl_word[CW_IR_OUT] = 1'b1;
          ctrl_word[CW_MAR_IN] = 1'b1;
        end else if (ir_op == OP_JMP) begin
          ctrl_word[CW_IR_OUT]  = 1'b1;
          ctrl_word[CW_PC_LOAD] = 1'b1;
          op_last               = 1'b1;
        end else if (ir_op == OP_OUT) begin
          ctrl_word[CW_A_OUT]  = 1'b1;
          ctrl_word[CW_OUT_IN] = 1'b1;
          op_last              = 1'b1;
        end else if (ir_op == OP_HLT) begin
          // HALT is entered from here independently of SKIP_NOP
          halt_step = 1'b1;
        end else begin
          op_last = 1'b1;  // NOP
        end
      end
      ST_T5: begin
        case (ir_op)
          OP_LDA: begin
            ctrl_word[CW_RAM_OUT] = 1'b1;
            ctrl_word[CW_A_IN]    = 1'b1;
            op_last               = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_word[CW_RAM_OUT] = 1'b1;
            ctrl_word[CW_B_IN]    = 1'b1;
            // select subtract a step early so the ALU result settles by T6
            ctrl_word[CW_ALU_SUB] = (ir_op == OP_SUB);
          end
          OP_STA: begin
            ctrl_word[CW_A_OUT]  = 1'b1;
            ctrl_word[CW_RAM_IN] = 1'b1;
            op_last              = 1'b1;
          end
          default: op_last = 1'b1;  // only reachable with SKIP_NOP=0
        endcase
      end
      ST_T6: begin
        if ((ir_op == OP_ADD) || (ir_op == OP_SUB)) begin
          ctrl_word[CW_ALU_OUT] = 1'b1;
          ctrl_word[CW_A_IN]    = 1'b1;
          ctrl_word[CW_ALU_SUB] = (ir_op == OP_SUB);
        end
        op_last = 1'b1;
      end
      default: ;  // HALT and the unused code drive nothing
    endcase
  end

  assign last_step = SKIP_NOP ? op_last : (state == ST_T6);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_seq
// Microcode control sequencer: steps T1..T6 (plus HALT) and drives every bus
// enable of the CPU. Strobes are a combinational decode of the state register
// and ir_op, valid for the whole cycle of their T-state.
// Ports:
//   clk, rst_n           clock / synchronous active-low reset (-> T1)
//   run                  step enable; 0 holds the state and its strobes
//   ir_op                opcode IR[7:4]
//   pc_out/pc_inc/pc_load, mar_in, ram_out/ram_in, ir_in/ir_out,
//   a_in/a_out, b_in, alu_out/alu_sub, out_in    bus control strobes
//   t_state              one-hot T1..T6, zero in HALT
//   halted               HALT state indicator
// -----------------------------------------------------------------------------
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter bit SKIP_NOP = 1'b1,
  parameter int TW       = STATE_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] ir_op,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_in,
  output logic [5:0] t_state,
  output logic       halted
);

  logic [TW-1:0] state_reg;
  logic [TW-1:0] state_next;
  ctrl_word_t    ctrl_word;
  logic          last_step;
  logic          halt_step;

  ctrl_decode #(
    .SKIP_NOP (SKIP_NOP)
  ) u_decode (
    .state     (state_reg),
    .ir_op     (ir_op),
    .ctrl_word (ctrl_word),
    .last_step (last_step),
    .halt_step (halt_step)
  );

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_HALT) begin
      state_next = ST_HALT;  // only reset leaves HALT
    end else if (run) begin
      if (halt_step) begin
        state_next = ST_HALT;
      end else if (last_step || (state_reg >= ST_T6)) begin
        // the >= arm also recovers from the unused code
        state_next = ST_T1;
      end else begin
        state_next = state_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_T1;
    end else begin
      state_reg <= state_next;
    end
  end

  // One-hot step indicator; all zero in HALT or the unused code.
  for (genvar gi = 0; gi < 6; gi++) begin : g_t_state
    assign t_state[gi] = (state_reg == ST_T1 + TW'(gi));
  end

  assign halted  = (state_reg == ST_HALT);

  assign pc_out  = ctrl_word[CW_PC_OUT];
  assign pc_inc  = ctrl_word[CW_PC_INC];
  assign pc_load = ctrl_word[CW_PC_LOAD];
  assign mar_in  = ctrl_word[CW_MAR_IN];
  assign ram_out = ctrl_word[CW_RAM_OUT];
  assign ram_in  = ctrl_word[CW_RAM_IN];
  assign ir_in   = ctrl_word[CW_IR_IN];
  assign ir_out  = ctrl_word[CW_IR_OUT];
  assign a_in    = ctrl_word[CW_A_IN];
  assign a_out   = ctrl_word[CW_A_OUT];
  assign b_in    = ctrl_word[CW_B_IN];
  assign alu_out = ctrl_word[CW_ALU_OUT];
  assign alu_sub = ctrl_word[CW_ALU_SUB];
  assign out_in  = ctrl_word[CW_OUT_IN];

  // Single bus driver: at most one source may drive the shared bus.
  a_single_bus_driver : assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0({pc_out, ram_out, ir_out, a_out, alu_out})
  );

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl_seq
// Directed bench for cpu_ctrl_seq. The stimulus process pushes the expected
// strobes / t_state / halted of each cycle into a queue; a monitor samples the
// DUT on the falling edge and compares against the queue head.
// dut1 runs with SKIP_NOP=1, dut0 with SKIP_NOP=0.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl_seq;

  // Expected one-hot steps
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
  localparam logic [5:0] TH = 6'b000000;

  // Strobe vector packing used by this bench only
  localparam logic [13:0] PCO  = 14'h2000;
  localparam logic [13:0] PCI  = 14'h1000;
  localparam logic [13:0] PCL  = 14'h0800;
  localparam logic [13:0] MARI = 14'h0400;
  localparam logic [13:0] RAMO = 14'h0200;
  localparam logic [13:0] RAMI = 14'h0100;
  localparam logic [13:0] IRI  = 14'h0080;
  localparam logic [13:0] IRO  = 14'h0040;
  localparam logic [13:0] AI   = 14'h0020;
  localparam logic [13:0] AO   = 14'h0010;
  localparam logic [13:0] BI   = 14'h0008;
  localparam logic [13:0] ALUO = 14'h0004;
  localparam logic [13:0] SUBS = 14'h0002;
  localparam logic [13:0] OUTI = 14'h0001;
  localparam logic [13:0] NONE = 14'h0000;

  typedef struct {
    string       name;
    logic        h;
    logic [5:0]  t;
    logic [13:0] s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, run1;
  logic [3:0] op1;
  logic       rst0_n, run0;
  logic [3:0] op0;

  logic pc_out1, pc_inc1, pc_load1, mar_in1, ram_out1, ram_in1, ir_in1, ir_out1;
  logic a_in1, a_out1, b_in1, alu_out1, alu_sub1, out_in1, halted1;
  logic [5:0] t_state1;
  logic pc_out0, pc_inc0, pc_load0, mar_in0, ram_out0, ram_in0, ir_in0, ir_out0;
  logic a_in0, a_out0, b_in0, alu_out0, alu_sub0, out_in0, halted0;
  logic [5:0] t_state0;

  cpu_ctrl_seq #(.SKIP_NOP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .run(run1), .ir_op(op1),
    .pc_out(pc_out1), .pc_inc(pc_inc1), .pc_load(pc_load1), .mar_in(mar_in1),
    .ram_out(ram_out1), .ram_in(ram_in1), .ir_in(ir_in1), .ir_out(ir_out1),
    .a_in(a_in1), .a_out(a_out1), .b_in(b_in1), .alu_out(alu_out1),
    .alu_sub(alu_sub1), .out_in(out_in1), .t_state(t_state1), .halted(halted1)
  );

  cpu_ctrl_seq #(.SKIP_NOP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .run(run0), .ir_op(op0),
    .pc_out(pc_out0), .pc_inc(pc_inc0), .pc_load(pc_load0), .mar_in(mar_in0),
    .ram_out(ram_out0), .ram_in(ram_in0), .ir_in(ir_in0), .ir_out(ir_out0),
    .a_in(a_in0), .a_out(a_out0), .b_in(b_in0), .alu_out(alu_out0),
    .alu_sub(alu_sub0), .out_in(out_in0), .t_state(t_state0), .halted(halted0)
  );

  exp_t q1[$];
  exp_t q0[$];
  int n_checks = 0;
  int n_fail   = 0;

  wire [13:0] act1 = {pc_out1, pc_inc1, pc_load1, mar_in1, ram_out1, ram_in1, ir_in1,
                      ir_out1, a_in1, a_out1, b_in1, alu_out1, alu_sub1, out_in1};
  wire [13:0] act0 = {pc_out0, pc_inc0, pc_load0, mar_in0, ram_out0, ram_in0, ir_in0,
                      ir_out0, a_in0, a_out0, b_in0, alu_out0, alu_sub0, out_in0};

  task automatic check(input string dut, input exp_t e, input logic [13:0] s,
                       input logic [5:0] t, input logic h);
    n_checks++;
    if ((s !== e.s) || (t !== e.t) || (h !== e.h)) begin
      n_fail++;
      $display("FAIL %s.%s: got halted=%b t_state=%b strobes=%b, expected halted=%b t_state=%b strobes=%b",
               dut, e.name, h, t, s, e.h, e.t, e.s);
    end else begin
      $display("txn %s.%s ok: halted=%b t_state=%b strobes=%b", dut, e.name, h, t, s);
    end
  endtask

  // Monitor: one comparison per expected cycle, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("dut1", e, act1, t_state1, halted1);
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("dut0", e, act0, t_state0, halted0);
    end
  end

  task automatic push(input int which, input string nm, input logic [5:0] t,
                      input logic [13:0] s, input logic h);
    exp_t e;
    e.name = nm;
    e.t    = t;
    e.s    = s;
    e.h    = h;
    if (which == 1) q1.push_back(e);
    else            q0.push_back(e);
  endtask

  // Advance one clock edge, then record what the DUT must show this cycle.
  task automatic step(input int which, input string nm, input logic [5:0] t,
                      input logic [13:0] s, input logic h);
    @(posedge clk);
    #1;
    push(which, nm, t, s, h);
  endtask

  task automatic fetch(input int which, input string op);
    step(which, {op, "_t2"}, T2, PCI, 1'b0);
    step(which, {op, "_t3"}, T3, RAMO | IRI, 1'b0);
  endtask

  initial begin
    rst1_n = 1'b0; run1 = 1'b1; op1 = 4'h0;
    rst0_n = 1'b0; run0 = 1'b1; op0 = 4'h0;

    // ---------------- dut1: SKIP_NOP = 1 ----------------
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    push(1, "reset", T1, PCO | MARI, 1'b0);

    // LDA: period 5
    fetch(1, "lda");
    step(1, "lda_t4", T4, IRO | MARI, 1'b0);
    step(1, "lda_t5", T5, RAMO | AI, 1'b0);
    step(1, "lda_wrap", T1, PCO | MARI, 1'b0);

    // SUB: alu_sub in T5 and T6 only
    op1 = 4'h2;
    fetch(1, "sub");
    step(1, "sub_t4", T4, IRO | MARI, 1'b0);
    step(1, "sub_t5", T5, RAMO | BI | SUBS, 1'b0);
    step(1, "sub_t6", T6, ALUO | AI | SUBS, 1'b0);
    step(1, "sub_wrap", T1, PCO | MARI, 1'b0);

    // JMP: period 4
    op1 = 4'h4;
    fetch(1, "jmp");
    step(1, "jmp_t4", T4, IRO | PCL, 1'b0);
    step(1, "jmp_wrap", T1, PCO | MARI, 1'b0);

    // OUT: period 4
    op1 = 4'hE;
    fetch(1, "out");
    step(1, "out_t4", T4, AO | OUTI, 1'b0);
    step(1, "out_wrap", T1, PCO | MARI, 1'b0);

    // STA
    op1 = 4'h3;
    fetch(1, "sta");
    step(1, "sta_t4", T4, IRO | MARI, 1'b0);
    step(1, "sta_t5", T5, AO | RAMI, 1'b0);
    step(1, "sta_wrap", T1, PCO | MARI, 1'b0);

    // Undefined opcode acts as NOP ending at T4
    op1 = 4'h7;
    fetch(1, "nop");
    step(1, "nop_t4", T4, NONE, 1'b0);
    step(1, "nop_wrap", T1, PCO | MARI, 1'b0);

    // ADD with run=0 held for three cycles in T5
    op1 = 4'h1;
    fetch(1, "add");
    step(1, "add_t4", T4, IRO | MARI, 1'b0);
    step(1, "add_t5", T5, RAMO | BI, 1'b0);
    run1 = 1'b0;
    for (int i = 0; i < 3; i++) step(1, "add_hold", T5, RAMO | BI, 1'b0);
    run1 = 1'b1;
    step(1, "add_t6", T6, ALUO | AI, 1'b0);
    step(1, "add_wrap", T1, PCO | MARI, 1'b0);

    // ADD aborted by reset in T5: no a_in pulse, straight to T1
    fetch(1, "add2");
    step(1, "add2_t4", T4, IRO | MARI, 1'b0);
    step(1, "add2_t5", T5, RAMO | BI, 1'b0);
    rst1_n = 1'b0;
    step(1, "rst_mid", T1, PCO | MARI, 1'b0);
    rst1_n = 1'b1;
    op1 = 4'hF;

    // HLT: HALT after T4, held with run toggling, left only by reset
    step(1, "hlt_t2", T2, PCI, 1'b0);
    step(1, "hlt_t3", T3, RAMO | IRI, 1'b0);
    step(1, "hlt_t4", T4, NONE, 1'b0);
    step(1, "halt", TH, NONE, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run1 = ~run1;
      step(1, "halt_hold", TH, NONE, 1'b1);
    end
    run1 = 1'b0;
    rst1_n = 1'b0;
    step(1, "halt_reset", T1, PCO | MARI, 1'b0);
    rst1_n = 1'b1;
    run1 = 1'b1;
    step(1, "post_halt_t2", T2, PCI, 1'b0);

    // ---------------- dut0: SKIP_NOP = 0 ----------------
    rst0_n = 1'b1;
    push(0, "d0_reset", T1, PCO | MARI, 1'b0);
    fetch(0, "d0_lda");
    step(0, "d0_lda_t4", T4, IRO | MARI, 1'b0);
    step(0, "d0_lda_t5", T5, RAMO | AI, 1'b0);
    step(0, "d0_lda_t6", T6, NONE, 1'b0);
    step(0, "d0_lda_wrap", T1, PCO | MARI, 1'b0);

    op0 = 4'h4;
    fetch(0, "d0_jmp");
    step(0, "d0_jmp_t4", T4, IRO | PCL, 1'b0);
    step(0, "d0_jmp_t5", T5, NONE, 1'b0);
    step(0, "d0_jmp_t6", T6, NONE, 1'b0);
    step(0, "d0_jmp_wrap", T1, PCO | MARI, 1'b0);

    op0 = 4'hF;
    fetch(0, "d0_hlt");
    step(0, "d0_hlt_t4", T4, NONE, 1'b0);
    step(0, "d0_halt", TH, NONE, 1'b1);
    step(0, "d0_halt_hold", TH, NONE, 1'b1);

    // Let the monitor drain the last entries
    @(negedge clk);
    #1;
    n_checks++;
    if ((q1.size() != 0) || (q0.size() != 0)) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q1.size(), q0.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
